// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, registered byte/strobe outputs and framing check.
// Optional even-parity frame support when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int BAUD_COUNT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_COUNT = BAUD_COUNT / 2;
    localparam logic [12:0] BAUD_LAST = 13'(BAUD_COUNT - 1);
    localparam logic [12:0] HALF_LAST = 13'(HALF_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t      state_r;
    logic [12:0] baud_cnt_r;
    logic [2:0]  bit_cnt_r;
    logic [7:0]  shift_r;
    logic        rxd_meta_r;
    logic        rxd_s;
    logic        rxd_d;

`ifdef UART_RX_PARITY_EN
    logic        parity_bit_r;

    function automatic logic even_parity_bad(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction
`else
    assign parity_err = 1'b0;
`endif

    // Two-flop synchroniser plus history flop for falling-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta_r <= 1'b1;
            rxd_s      <= 1'b1;
            rxd_d      <= 1'b1;
        end else begin
            rxd_meta_r <= rxd;
            rxd_s      <= rxd_meta_r;
            rxd_d      <= rxd_s;
        end
    end

    // Receive FSM with registered outputs; pulses default low every cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            baud_cnt_r   <= 13'd0;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            data_out     <= 8'h00;
            data_valid   <= 1'b0;
            rx_busy      <= 1'b0;
            frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_r <= 1'b0;
            parity_err   <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    baud_cnt_r <= 13'd0;
                    bit_cnt_r  <= 3'd0;
                    if (rxd_d && !rxd_s) begin
                        state_r <= START;
                        rx_busy <= 1'b1;
                    end else begin
                        rx_busy <= 1'b0;
                    end
                end
                START: begin
                    if (baud_cnt_r == HALF_LAST) begin
                        baud_cnt_r <= 13'd0;
                        bit_cnt_r  <= 3'd0;
                        if (!rxd_s) begin
                            state_r <= DATA;
                        end else begin
                            // Start bit gone by its centre: treat as a glitch
                            state_r <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 13'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt_r == BAUD_LAST) begin
                        baud_cnt_r <= 13'd0;
                        shift_r    <= {rxd_s, shift_r[7:1]};
                        if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_r <= PARITY;
`else
                            state_r <= STOP;
`endif
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 13'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (baud_cnt_r == BAUD_LAST) begin
                        baud_cnt_r   <= 13'd0;
                        parity_bit_r <= rxd_s;
                        state_r      <= STOP;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 13'd1;
                    end
                end
`endif
                STOP: begin
                    if (baud_cnt_r == BAUD_LAST) begin
                        // Leave at stop-bit centre so a following start edge is not missed
                        baud_cnt_r <= 13'd0;
                        state_r    <= IDLE;
                        rx_busy    <= 1'b0;
                        if (!rxd_s) begin
                            frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (even_parity_bad(shift_r, parity_bit_r)) begin
                            parity_err <= 1'b1;
`endif
                        end else begin
                            data_out   <= shift_r;
                            data_valid <= 1'b1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 13'd1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    baud_cnt_r <= 13'd0;
                    bit_cnt_r  <= 3'd0;
                    rx_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
